// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with row
// debounce, key encoding and a 4-deep key event FIFO.
module keypad_scan_ctrl #(
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [3:0] row,
  output logic [3:0] column,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       irq,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam logic [7:0]  SET_MAX = 8'(SETTLE - 1);
  localparam logic [15:0] DEB_MAX = 16'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DEB,
    S_HELD
  } state_t;

  state_t      state;
  logic [1:0]  ci;
  logic [7:0]  scnt;
  logic [15:0] dcnt;
  logic [3:0]  cand;
  logic [3:0]  rs1;
  logic [3:0]  rs;

  logic [1:0]  ri;
  logic        one;
  logic [3:0]  code;
  logic        push;

  logic [3:0]  mem [4];
  logic [1:0]  wp;
  logic [1:0]  rp;
  logic [2:0]  cnt;
  logic        pop;
  logic        full;
  logic        wr;
  logic        ovf_set;
  logic [1:0]  rp_n;
  logic [2:0]  cnt_n;
  logic [3:0]  head_n;

  // two-flop synchronizer for the asynchronous rows
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      rs1 <= 4'hf;
      rs  <= 4'hf;
    end else begin
      rs1 <= row;
      rs  <= rs1;
    end
  end

  // column strobe decode; all released while idle
  always_comb begin
    column = 4'hf;
    if (state != S_IDLE) begin
      unique case (ci)
        2'd0: column = 4'b0111;
        2'd1: column = 4'b1011;
        2'd2: column = 4'b1101;
        2'd3: column = 4'b1110;
      endcase
    end
  end

  // row index of the candidate; one is set for a single key
  always_comb begin
    ri  = 2'd0;
    one = 1'b0;
    unique case (cand)
      4'b1110: begin ri = 2'd0; one = 1'b1; end
      4'b1101: begin ri = 2'd1; one = 1'b1; end
      4'b1011: begin ri = 2'd2; one = 1'b1; end
      4'b0111: begin ri = 2'd3; one = 1'b1; end
      default: ;
    endcase
  end

  // key code table indexed by column and row
  always_comb begin
    code = 4'h0;
    unique case ({ci, ri})
      4'h0: code = 4'hf;
      4'h1: code = 4'h0;
      4'h2: code = 4'he;
      4'h3: code = 4'hd;
      4'h4: code = 4'h7;
      4'h5: code = 4'h8;
      4'h6: code = 4'h9;
      4'h7: code = 4'hc;
      4'h8: code = 4'h4;
      4'h9: code = 4'h5;
      4'ha: code = 4'h6;
      4'hb: code = 4'hb;
      4'hc: code = 4'h1;
      4'hd: code = 4'h2;
      4'he: code = 4'h3;
      4'hf: code = 4'ha;
    endcase
  end

  assign push = scan_en && (state == S_DEB)
             && (rs == cand) && (dcnt == DEB_MAX)
             && one;

  // scan / settle / debounce / held sequencer
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state <= S_SETTLE;
      ci    <= 2'd0;
      scnt  <= 8'd0;
      dcnt  <= 16'd0;
      cand  <= 4'hf;
    end else if (!scan_en) begin
      state <= S_IDLE;
      scnt  <= 8'd0;
      dcnt  <= 16'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_SETTLE;
          scnt  <= 8'd0;
        end
        S_SETTLE: begin
          if (scnt == SET_MAX) begin
            scnt <= 8'd0;
            if (rs == 4'hf) begin
              ci <= ci + 2'd1;
            end else begin
              cand  <= rs;
              dcnt  <= 16'd0;
              state <= S_DEB;
            end
          end else begin
            scnt <= scnt + 8'd1;
          end
        end
        S_DEB: begin
          if (rs != cand) begin
            state <= S_SETTLE;
            scnt  <= 8'd0;
          end else if (dcnt == DEB_MAX) begin
            dcnt  <= 16'd0;
            state <= S_HELD;
          end else begin
            dcnt <= dcnt + 16'd1;
          end
        end
        S_HELD: begin
          if (rs != 4'hf) begin
            dcnt <= 16'd0;
          end else if (dcnt == DEB_MAX) begin
            dcnt  <= 16'd0;
            scnt  <= 8'd0;
            ci    <= ci + 2'd1;
            state <= S_SETTLE;
          end else begin
            dcnt <= dcnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign pop     = key_ack && key_valid;
  assign full    = (cnt == 3'd4);
  assign wr      = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign rp_n    = pop ? rp + 2'd1 : rp;
  assign cnt_n   = cnt + {2'b0, wr} - {2'b0, pop};

  // head after this edge; bypass when the write lands at the head
  always_comb begin
    head_n = mem[rp_n];
    if (wr && (wp == rp_n)) head_n = code;
  end

  // event storage
  always_ff @(posedge clk1) begin
    if (wr) mem[wp] <= code;
  end

  // FIFO pointers, registered head, irq and overflow flag
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      wp        <= 2'd0;
      rp        <= 2'd0;
      cnt       <= 3'd0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      irq       <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr) wp <= wp + 2'd1;
      rp        <= rp_n;
      cnt       <= cnt_n;
      key_valid <= (cnt_n != 3'd0);
      key_code  <= (cnt_n != 3'd0) ? head_n : 4'h0;
      irq       <= key_valid;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench with a keypad matrix
// model driving rows from the strobed columns.
module tb_keypad_scan_ctrl;

  logic       clk1 = 1'b0;
  logic       reset;
  logic       scan_en;
  logic [3:0] row;
  logic [3:0] column;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       irq;
  logic       overflow;
  logic       ovf_clr;

  logic [3:0] prs [4];
  int checks = 0;
  int errors = 0;
  logic seen;

  keypad_scan_ctrl #(.SETTLE(4), .DEBOUNCE(16)) dut (
    .clk1      (clk1),
    .reset     (reset),
    .scan_en   (scan_en),
    .row       (row),
    .column    (column),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .irq       (irq),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk1 = ~clk1;

  // keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hf;
    for (int c = 0; c < 4; c++) begin
      if (!column[3-c]) row = row & ~prs[c];
    end
  end

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic wait_col(input string tag,
                          input logic [3:0] val,
                          input int max);
    int k = 0;
    while (column !== val && k < max) begin
      tick(1);
      k++;
    end
    chk(tag, {4'h0, column}, {4'h0, val});
  endtask

  task automatic wait_not_col(input logic [3:0] val);
    int k = 0;
    while (column === val && k < 40) begin
      tick(1);
      k++;
    end
  endtask

  task automatic press_key(input int c, input int r);
    prs[c][r] = 1'b1;
    tick(60);
    prs[c][r] = 1'b0;
    tick(40);
  endtask

  task automatic ack1;
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_q [4];
    int k;
    for (int c = 0; c < 4; c++) prs[c] = 4'h0;
    reset   = 1'b1;
    scan_en = 1'b1;
    key_ack = 1'b0;
    ovf_clr = 1'b0;
    #3;
    chk("rst_column", {4'h0, column}, 8'h07);
    chk("rst_valid", {7'h0, key_valid}, 8'h0);
    chk("rst_code", {4'h0, key_code}, 8'h0);
    chk("rst_irq", {7'h0, irq}, 8'h0);
    chk("rst_ovf", {7'h0, overflow}, 8'h0);

    // key 5 (column 2, row 1) already down when reset releases
    prs[2][1] = 1'b1;
    @(negedge clk1);
    reset = 1'b0;
    tick(27);
    chk("k5_before", {7'h0, key_valid}, 8'h0);
    tick(1);
    chk("k5_valid", {7'h0, key_valid}, 8'h1);
    chk("k5_code", {4'h0, key_code}, 8'h05);
    chk("k5_irq_lag", {7'h0, irq}, 8'h0);
    tick(1);
    chk("k5_irq", {7'h0, irq}, 8'h1);
    tick(1);
    prs[2][1] = 1'b0;
    tick(17);
    chk("held_col", {4'h0, column}, 8'h0d);
    tick(1);
    chk("resume_ci3", {4'h0, column}, 8'h0e);
    ack1();
    chk("k5_pop_valid", {7'h0, key_valid}, 8'h0);
    chk("k5_pop_code", {4'h0, key_code}, 8'h0);
    chk("k5_pop_irq", {7'h0, irq}, 8'h1);
    tick(1);
    chk("k5_irq_fall", {7'h0, irq}, 8'h0);

    // bounce on column 0, row 0, then a stable hold
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      prs[0][0] = ~prs[0][0];
      for (int j = 0; j < 5; j++) begin
        tick(1);
        seen = seen | key_valid;
      end
    end
    chk("bounce_quiet", {7'h0, seen}, 8'h0);
    prs[0][0] = 1'b1;
    k = 0;
    while (!key_valid && k < 80) begin
      tick(1);
      k++;
    end
    chk("bounce_valid", {7'h0, key_valid}, 8'h1);
    chk("bounce_code", {4'h0, key_code}, 8'h0f);
    prs[0][0] = 1'b0;
    tick(40);
    ack1();
    chk("bounce_one", {7'h0, key_valid}, 8'h0);

    // two keys in column 1: ghost, no event, scanner parks
    prs[1] = 4'b0011;
    wait_col("multi_reach", 4'b1011, 40);
    tick(40);
    chk("multi_park", {4'h0, column}, 8'h0b);
    chk("multi_none", {7'h0, key_valid}, 8'h0);
    chk("multi_ovf", {7'h0, overflow}, 8'h0);
    prs[1] = 4'h0;
    tick(40);

    // five presses without ack
    press_key(3, 0);
    press_key(3, 1);
    press_key(3, 2);
    press_key(3, 3);
    press_key(1, 0);
    chk("ovf_set", {7'h0, overflow}, 8'h1);
    chk("ovf_head", {4'h0, key_code}, 8'h01);
    exp_q[0] = 4'h1;
    exp_q[1] = 4'h2;
    exp_q[2] = 4'h3;
    exp_q[3] = 4'ha;
    key_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", {4'h0, key_code}, {4'h0, exp_q[i]});
      tick(1);
    end
    key_ack = 1'b0;
    chk("ovf_empty", {7'h0, key_valid}, 8'h0);
    chk("ovf_empty_code", {4'h0, key_code}, 8'h0);
    tick(1);
    chk("ovf_irq_fall", {7'h0, irq}, 8'h0);
    chk("ovf_sticky", {7'h0, overflow}, 8'h1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", {7'h0, overflow}, 8'h0);

    // full FIFO, push of 7 coincides with a pop
    press_key(3, 0);
    press_key(3, 1);
    press_key(3, 2);
    press_key(3, 3);
    chk("full_ovf0", {7'h0, overflow}, 8'h0);
    wait_not_col(4'b1011);
    prs[1][0] = 1'b1;
    wait_col("pp_reach", 4'b1011, 40);
    tick(19);
    chk("pp_pre_head", {4'h0, key_code}, 8'h01);
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    chk("pp_valid", {7'h0, key_valid}, 8'h1);
    chk("pp_head", {4'h0, key_code}, 8'h02);
    chk("pp_ovf", {7'h0, overflow}, 8'h0);
    prs[1][0] = 1'b0;
    tick(40);
    exp_q[0] = 4'h2;
    exp_q[1] = 4'h3;
    exp_q[2] = 4'ha;
    exp_q[3] = 4'h7;
    key_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_drain", {4'h0, key_code}, {4'h0, exp_q[i]});
      tick(1);
    end
    key_ack = 1'b0;
    chk("pp_empty", {7'h0, key_valid}, 8'h0);

    // disable while debouncing key 1
    wait_not_col(4'b1110);
    prs[3][0] = 1'b1;
    wait_col("dis_reach", 4'b1110, 40);
    tick(10);
    scan_en = 1'b0;
    tick(1);
    chk("dis_col", {4'h0, column}, 8'h0f);
    tick(30);
    chk("dis_none", {7'h0, key_valid}, 8'h0);
    chk("dis_col_hold", {4'h0, column}, 8'h0f);
    prs[3][0] = 1'b0;
    scan_en = 1'b1;
    tick(1);
    chk("en_resume", {4'h0, column}, 8'h0e);
    tick(20);

    // two entries queued, then asynchronous reset
    press_key(2, 1);
    press_key(2, 2);
    chk("q2_valid", {7'h0, key_valid}, 8'h1);
    chk("q2_head", {4'h0, key_code}, 8'h05);
    chk("q2_irq", {7'h0, irq}, 8'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {7'h0, key_valid}, 8'h0);
    chk("arst_irq", {7'h0, irq}, 8'h0);
    chk("arst_col", {4'h0, column}, 8'h07);
    chk("arst_code", {4'h0, key_code}, 8'h0);
    @(negedge clk1);
    reset = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequencing controller for the 4x4 matrix keypad. It drives the column strobes and synchronizes and debounces the active-low row returns. Each clean key press is encoded as a 4-bit key code and queued in a 4-entry event FIFO, which the bus-side wrapper drains through a valid/ack handshake with a level interrupt.

## Interface
Parameters:
- SETTLE, default 4: cycles a column is driven before row is sampled (1..255).
- DEBOUNCE, default 16: consecutive identical samples needed to accept a press or a release (1..65535).

Ports:
- clk1  in  1  clock.
- reset  in  1  asynchronous, active-high.
- scan_en  in  1  1 = scanning enabled.
- row  in  4  keypad rows, active-low, asynchronous to clk1.
- column  out  4  column strobes, active-low, one-hot-zero.
- key_code  out  4  code at FIFO head; 0 when empty.
- key_valid  out  1  FIFO non-empty.
- key_ack  in  1  pop head; ignored when key_valid = 0.
- irq  out  1  registered copy of key_valid.
- overflow  out  1  sticky flag: a press was dropped because the FIFO was full.
- ovf_clr  in  1  clears overflow.

## Operation
- row passes through a 2-flop synchronizer. All decisions below use the synchronized value rs.
- Column index ci (0..3) drives column: 0→0111, 1→1011, 2→1101, 3→1110. When scan_en = 0, column = 1111.
- Key code for (ci, rs):
  - ci0: 1110→F, 1101→0, 1011→E, 0111→D
  - ci1: 7, 8, 9, C (same row order)
  - ci2: 4, 5, 6, B
  - ci3: 1, 2, 3, A
- FSM states: IDLE, SETTLE, DEBOUNCE, HELD.
  - IDLE: entered whenever scan_en = 0, from any state; counters cleared, ci held. Exits to SETTLE when scan_en = 1.
  - SETTLE: counts SETTLE cycles, then samples rs.
    - rs = 1111: ci ← ci+1 (mod 4, 3→0) and SETTLE restarts.
    - otherwise: latch the sample as cand and go to DEBOUNCE.
  - DEBOUNCE: column held.
    - Each cycle with rs == cand increments the counter.
    - rs ≠ cand (including release): return to SETTLE on the same ci, no event.
    - Counter reaches DEBOUNCE: if cand has exactly one zero bit, push the code; if it has two or more zeros (ghosting or multi-key), push nothing. Either way go to HELD.
  - HELD: column held.
    - rs must read 1111 for DEBOUNCE consecutive cycles; any non-1111 sample restarts the count.
    - Then ci ← ci+1 and go to SETTLE. No repeat events while a key is held.
- FIFO: depth 4, 3-bit occupancy count.
  - Push when full: the press is dropped and overflow is set.
  - Push and pop in the same cycle: both take effect, occupancy unchanged. When full, this push is not dropped.
  - A pop occurs when key_ack = 1 and key_valid = 1.
- overflow: ovf_clr clears it. If a set and ovf_clr occur in the same cycle, the set wins.

## Timing
- Reset values: column 0111, ci 0, state SETTLE (IDLE if scan_en = 0 on the first clock), key_code 0, key_valid 0, irq 0, overflow 0, FIFO empty, synchronizer 1111.
- Row latency is 2 cycles. rs reflects row two clk1 edges after row changes.
- Press latency: from rs first showing the key during SETTLE sampling, the push lands on the DEBOUNCE-th subsequent edge. key_valid/key_code update on that same edge; irq follows one cycle later.
- key_valid and key_code are registered. After a pop, the next entry appears the following cycle. Back-to-back acks drain one entry per cycle.
- irq falls one cycle after key_valid falls.
- Asserting reset mid-debounce or mid-HELD discards all state immediately (asynchronous). No event is produced.

## Test plan
- Press ci2/row 1101 for 30 cycles, then release, with SETTLE=4 and DEBOUNCE=16: exactly one entry, key_code = 5; key_valid high; irq high one cycle later; scanning resumes at ci3 after 16 clean cycles.
- Bounce: toggle row between 1110 and 1111 every 5 cycles for 60 cycles on ci0, then hold 1110: exactly one event, code F, only after the stable hold.
- Multi-key: row 1100 on ci1, held for 40 cycles: no event; FSM reaches HELD; overflow stays 0.
- Overflow: five presses (codes 1, 2, 3, A, 7) with no ack: FIFO holds 1, 2, 3, A; overflow = 1. Then ack 4 times on consecutive cycles: codes read 1, 2, 3, A; key_valid = 0 afterwards. Then ovf_clr: overflow = 0.
- Push with pop when full: FIFO full with key_ack=1 on the same cycle as a new press: occupancy stays 4, new code at the tail, overflow stays 0.
- Disable and reset: scan_en=0 mid-DEBOUNCE gives column = 1111 and no event. Asserting reset while 2 entries are queued gives key_valid = 0, irq = 0, column = 0111 with no clock edge.
